// File: rtl/vga_pkg.sv
// Geometry, colours and shared types for the VGA text-box overlay.
// Every dimension used by draw_rect_char is derived from the constants here.
package vga_pkg;

    localparam int unsigned CNT_W = 11;
    localparam int unsigned RGB_W = 12;

    localparam int unsigned TEXT_COLS = 16;
    localparam int unsigned TEXT_ROWS = 16;
    localparam int unsigned GLYPH_W   = 8;
    localparam int unsigned GLYPH_H   = 16;

    localparam int unsigned GLYPH_X_BITS = $clog2(GLYPH_W);
    localparam int unsigned GLYPH_Y_BITS = $clog2(GLYPH_H);
    localparam int unsigned COL_BITS     = $clog2(TEXT_COLS);
    localparam int unsigned ROW_BITS     = $clog2(TEXT_ROWS);
    localparam int unsigned BOX_X_BITS   = GLYPH_X_BITS + COL_BITS;
    localparam int unsigned BOX_Y_BITS   = GLYPH_Y_BITS + ROW_BITS;
    localparam int unsigned CHAR_XY_W    = ROW_BITS + COL_BITS;
    localparam int unsigned CHAR_LINE_W  = GLYPH_Y_BITS;

    localparam logic [CNT_W-1:0] RECT_CHAR_X = 11'd655;
    localparam logic [CNT_W-1:0] RECT_CHAR_Y = 11'd100;
    localparam logic [CNT_W-1:0] RECT_CHAR_X_END = RECT_CHAR_X + CNT_W'(TEXT_COLS * GLYPH_W - 1);
    localparam logic [CNT_W-1:0] RECT_CHAR_Y_END = RECT_CHAR_Y + CNT_W'(TEXT_ROWS * GLYPH_H - 1);

    localparam logic [RGB_W-1:0] LETTERS = 12'hf00;
    localparam logic [RGB_W-1:0] BG      = 12'hfff;

    typedef struct packed {
        logic [CNT_W-1:0] vcount;
        logic [CNT_W-1:0] hcount;
        logic             vsync;
        logic             hsync;
        logic             vblnk;
        logic             hblnk;
    } vga_timing_t;

    // Bounds are compared on the raw counters, so nothing below the box origin can wrap in.
    function automatic logic box_hit(
        input logic [CNT_W-1:0] hcount,
        input logic [CNT_W-1:0] vcount,
        input logic             hblnk,
        input logic             vblnk
    );
        logic h_ok;
        logic v_ok;
        h_ok = (hcount >= RECT_CHAR_X) && (hcount <= RECT_CHAR_X_END);
        v_ok = (vcount >= RECT_CHAR_Y) && (vcount <= RECT_CHAR_Y_END);
        return h_ok && v_ok && !(hblnk || vblnk);
    endfunction

endpackage

// File: rtl/draw_rect_char_if.sv
// Pixel stream in/out plus the char/font ROM lookup signals of draw_rect_char.
// slave is the overlay's view; master is the view of whoever drives the stream and ROMs.
interface draw_rect_char_if;
    import vga_pkg::*;

    logic [CNT_W-1:0]       vcount_in;
    logic [CNT_W-1:0]       hcount_in;
    logic                   vsync_in;
    logic                   hsync_in;
    logic                   vblnk_in;
    logic                   hblnk_in;
    logic [RGB_W-1:0]       rgb_in;
    logic [GLYPH_W-1:0]     char_pixels;

    logic [CNT_W-1:0]       vcount_out;
    logic [CNT_W-1:0]       hcount_out;
    logic                   vsync_out;
    logic                   hsync_out;
    logic                   vblnk_out;
    logic                   hblnk_out;
    logic [RGB_W-1:0]       rgb_out;
    logic [CHAR_XY_W-1:0]   char_xy;
    logic [CHAR_LINE_W-1:0] char_line;

    modport slave (
        input  vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in, rgb_in,
        input  char_pixels,
        output vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out, rgb_out,
        output char_xy, char_line
    );

    modport master (
        output vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in, rgb_in,
        output char_pixels,
        input  vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out, rgb_out,
        input  char_xy, char_line
    );

endinterface

// File: rtl/delay.sv
// Fixed-latency shift register: dout is din delayed by CLK_DEL clock cycles.
// Clears asynchronously so no stale data leaves the pipe after reset.
module delay #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [CLK_DEL-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int unsigned i = 1; i < CLK_DEL; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_rect_char.sv
// Overlays a 16x16 text box of 8x16 glyphs on a VGA pixel stream.
// Char/font ROMs are external: char_xy/char_line go out at +1, char_pixels returns at +2.
module draw_rect_char
    import vga_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    draw_rect_char_if.slave bus
);

    logic                    in_box;
    logic [BOX_X_BITS-1:0]   x_off;
    logic [BOX_Y_BITS-1:0]   y_off;

    always_comb begin
        in_box = box_hit(bus.hcount_in, bus.vcount_in, bus.hblnk_in, bus.vblnk_in);
        x_off  = BOX_X_BITS'(bus.hcount_in - RECT_CHAR_X);
        y_off  = BOX_Y_BITS'(bus.vcount_in - RECT_CHAR_Y);
    end

    logic [CHAR_XY_W-1:0]         char_xy_q;
    logic [CHAR_LINE_W-1:0]       char_line_q;
    logic [1:0]                   in_box_pipe;
    logic [1:0][GLYPH_X_BITS-1:0] col_pipe;
    logic [RGB_W-1:0]             rgb_q;
    logic [RGB_W-1:0]             rgb_dly;
    logic                         glyph_on;

    // Stage 2 of in_box/col lines up with char_pixels coming back from the font ROM.
    assign glyph_on = bus.char_pixels[GLYPH_X_BITS'(GLYPH_W - 1) - col_pipe[1]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_xy_q   <= '0;
            char_line_q <= '0;
            in_box_pipe <= '0;
            col_pipe    <= '0;
            rgb_q       <= '0;
        end else begin
            if (in_box) begin
                char_xy_q   <= {y_off[GLYPH_Y_BITS +: ROW_BITS], x_off[GLYPH_X_BITS +: COL_BITS]};
                char_line_q <= y_off[0 +: GLYPH_Y_BITS];
            end else begin
                char_xy_q   <= '0;
                char_line_q <= '0;
            end
            in_box_pipe <= {in_box_pipe[0], in_box};
            col_pipe    <= {col_pipe[0], x_off[0 +: GLYPH_X_BITS]};
            if (in_box_pipe[1]) begin
                rgb_q <= glyph_on ? LETTERS : BG;
            end else begin
                rgb_q <= rgb_dly;
            end
        end
    end

    vga_timing_t timing_in;
    vga_timing_t timing_out;

    assign timing_in = '{
        vcount: bus.vcount_in,
        hcount: bus.hcount_in,
        vsync:  bus.vsync_in,
        hsync:  bus.hsync_in,
        vblnk:  bus.vblnk_in,
        hblnk:  bus.hblnk_in
    };

    delay #(
        .WIDTH   ($bits(vga_timing_t)),
        .CLK_DEL (3)
    ) u_timing_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (timing_in),
        .dout  (timing_out)
    );

    // Two stages here plus rgb_q makes the pass-through colour 3 cycles, like the timing path.
    delay #(
        .WIDTH   (RGB_W),
        .CLK_DEL (2)
    ) u_rgb_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.rgb_in),
        .dout  (rgb_dly)
    );

    assign bus.vcount_out = timing_out.vcount;
    assign bus.hcount_out = timing_out.hcount;
    assign bus.vsync_out  = timing_out.vsync;
    assign bus.hsync_out  = timing_out.hsync;
    assign bus.vblnk_out  = timing_out.vblnk;
    assign bus.hblnk_out  = timing_out.hblnk;
    assign bus.rgb_out    = rgb_q;
    assign bus.char_xy    = char_xy_q;
    assign bus.char_line  = char_line_q;

endmodule

// File: tb/tb_draw_rect_char.sv
// Self-checking bench for draw_rect_char: models char/font ROMs and predicts every
// output pixel from box geometry arithmetic, compared through a queue of pending pixels.
module tb_draw_rect_char;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    draw_rect_char_if bus ();

    draw_rect_char dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [10:0] v;
        logic [10:0] h;
        logic        vs;
        logic        hs;
        logic        vb;
        logic        hb;
        logic [11:0] rgb;
    } px_t;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  font_mode = 0;
    px_t exp_q[$];

    function automatic logic [7:0] font_fn(input logic [7:0] xy, input logic [3:0] line, input int mode);
        if (mode == 1) return 8'h80;
        return 8'(int'(xy) * 37 + int'(line) * 11 + 90);
    endfunction

    // Registered font ROM fed by the (combinational) char ROM, i.e. directly by char_xy.
    always @(posedge clk) bus.char_pixels <= font_fn(bus.char_xy, bus.char_line, font_mode);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic inside_box(input px_t p);
        return p.h >= 655 && p.h <= 782 && p.v >= 100 && p.v <= 355 && !p.hb && !p.vb;
    endfunction

    function automatic int ref_xy(input px_t p);
        if (!inside_box(p)) return 0;
        return ((int'(p.v) - 100) / 16) * 16 + (int'(p.h) - 655) / 8;
    endfunction

    function automatic int ref_line(input px_t p);
        if (!inside_box(p)) return 0;
        return (int'(p.v) - 100) % 16;
    endfunction

    function automatic logic [11:0] ref_rgb(input px_t p, input int mode);
        logic [7:0] bits;
        int x;
        if (!inside_box(p)) return p.rgb;
        x = int'(p.h) - 655;
        bits = font_fn(8'(ref_xy(p)), 4'(ref_line(p)), mode);
        return bits[7 - (x % 8)] ? 12'hf00 : 12'hfff;
    endfunction

    function automatic px_t mk(input int h, input int v, input logic hb, input logic vb);
        px_t p;
        p.h   = 11'(h);
        p.v   = 11'(v);
        p.hb  = hb;
        p.vb  = vb;
        p.hs  = 1'($urandom_range(0, 1));
        p.vs  = 1'($urandom_range(0, 1));
        p.rgb = 12'($urandom);
        return p;
    endfunction

    // Apply one pixel, clock it in, then check char lookup for it and stream output from 2 pixels back.
    task automatic drive(input px_t p);
        px_t e;
        bus.vcount_in = p.v;
        bus.hcount_in = p.h;
        bus.vsync_in  = p.vs;
        bus.hsync_in  = p.hs;
        bus.vblnk_in  = p.vb;
        bus.hblnk_in  = p.hb;
        bus.rgb_in    = p.rgb;
        e = p;
        e.rgb = ref_rgb(p, font_mode);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check("char_xy", 32'(bus.char_xy), 32'(ref_xy(p)));
        check("char_line", 32'(bus.char_line), 32'(ref_line(p)));
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            check("rgb_out", 32'(bus.rgb_out), 32'(e.rgb));
            check("hcount_out", 32'(bus.hcount_out), 32'(e.h));
            check("vcount_out", 32'(bus.vcount_out), 32'(e.v));
            check("hsync_out", 32'(bus.hsync_out), 32'(e.hs));
            check("vsync_out", 32'(bus.vsync_out), 32'(e.vs));
            check("hblnk_out", 32'(bus.hblnk_out), 32'(e.hb));
            check("vblnk_out", 32'(bus.vblnk_out), 32'(e.vb));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(mk(0, 0, 1'b0, 1'b0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rgb"}, 32'(bus.rgb_out), 32'd0);
        check({tag, "_hcount"}, 32'(bus.hcount_out), 32'd0);
        check({tag, "_vcount"}, 32'(bus.vcount_out), 32'd0);
        check({tag, "_syncs"}, 32'({bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out}), 32'd0);
        check({tag, "_char_xy"}, 32'(bus.char_xy), 32'd0);
        check({tag, "_char_line"}, 32'(bus.char_line), 32'd0);
    endtask

    task automatic push_reset_zeros();
        px_t z;
        z = '{default: '0};
        exp_q.delete();
        exp_q.push_back(z);
        exp_q.push_back(z);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        px_t p;
        logic [11:0] r_a;
        logic [11:0] r_b;

        bus.vcount_in = '0; bus.hcount_in = '0; bus.vsync_in = 1'b0; bus.hsync_in = 1'b0;
        bus.vblnk_in = 1'b0; bus.hblnk_in = 1'b0; bus.rgb_in = 12'h5a5;
        bus.vcount_in = 11'd150; bus.hcount_in = 11'd700;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        push_reset_zeros();
        idle(4);

        // Font returns 8'h80: only the leftmost column of each glyph is lit.
        font_mode = 1;
        idle(2);
        drive(mk(655, 100, 1'b0, 1'b0));
        check("s1_char_xy", 32'(bus.char_xy), 32'h00);
        check("s1_char_line", 32'(bus.char_line), 32'h0);
        idle(2);
        check("s1_rgb", 32'(bus.rgb_out), 32'hf00);

        drive(mk(662, 100, 1'b0, 1'b0));
        idle(2);
        check("s2_rgb", 32'(bus.rgb_out), 32'hfff);
        idle(3);
        font_mode = 0;

        drive(mk(782, 355, 1'b0, 1'b0));
        check("s3_char_xy", 32'(bus.char_xy), 32'hff);
        check("s3_char_line", 32'(bus.char_line), 32'hf);
        p = mk(783, 355, 1'b0, 1'b0);
        r_a = p.rgb;
        drive(p);
        check("s3_right_char_xy", 32'(bus.char_xy), 32'h00);
        p = mk(654, 100, 1'b0, 1'b0);
        r_b = p.rgb;
        drive(p);
        check("s3_left_char_xy", 32'(bus.char_xy), 32'h00);
        idle(1);
        check("s3_right_rgb", 32'(bus.rgb_out), 32'(r_a));
        idle(1);
        check("s3_left_rgb", 32'(bus.rgb_out), 32'(r_b));

        p = mk(700, 200, 1'b1, 1'b0);
        r_a = p.rgb;
        drive(p);
        check("s4_char_xy", 32'(bus.char_xy), 32'h00);
        idle(2);
        check("s4_rgb", 32'(bus.rgb_out), 32'(r_a));
        check("s4_hcount", 32'(bus.hcount_out), 32'd700);
        check("s4_vcount", 32'(bus.vcount_out), 32'd200);
        check("s4_hblnk", 32'(bus.hblnk_out), 32'd1);

        // Mid-frame reset inside the box: outputs clear at once, stay clear until refilled.
        for (int i = 0; i < 3; i++) drive(mk(720 + i, 150, 1'b0, 1'b0));
        p = mk(720, 150, 1'b0, 1'b0);
        bus.hcount_in = p.h; bus.vcount_in = p.v; bus.rgb_in = p.rgb;
        #3 rst_n = 1'b0;
        #1 check_zero("rst_async");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        rst_n = 1'b1;
        push_reset_zeros();
        for (int i = 0; i < 4; i++) drive(mk(720, 150, 1'b0, 1'b0));

        // Raster sweep around the box with occasional blanking inside it.
        for (int v = 96; v <= 359; v++) begin
            for (int h = 648; h <= 790; h++) begin
                drive(mk(h, v, 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 47) == 0)));
            end
        end

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 1)
                p = mk(int'($urandom_range(650, 790)), int'($urandom_range(95, 360)),
                       1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
            else
                p = mk(int'($urandom_range(0, 1055)), int'($urandom_range(0, 627)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drive(p);
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
